// File: rtl/alarm_irq_controller.sv
// Alarm interrupt controller: sticky pending/overrun per channel, serviced lowest index first.
// Optional macro ALARM_IRQ_EDGE_DETECT_EN turns alarm levels into rising-edge events.
module alarm_irq_controller #(
  parameter int NB_CAPTURES = 10,
  parameter int ID_BITWIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NB_CAPTURES-1:0] alarm_i,
  input  logic [NB_CAPTURES-1:0] irq_mask_i,
  input  logic                   irq_ack_i,
  input  logic [NB_CAPTURES-1:0] ovr_clear_i,
  output logic                   irq_o,
  output logic [ID_BITWIDTH-1:0] irq_id_o,
  output logic [NB_CAPTURES-1:0] pending_o,
  output logic [NB_CAPTURES-1:0] overrun_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic [1:0]             state;
  logic [NB_CAPTURES-1:0] ev;
  logic [NB_CAPTURES-1:0] ready;
  logic [NB_CAPTURES-1:0] serve_clr;
  logic [NB_CAPTURES-1:0] ovr_set;
  logic [ID_BITWIDTH-1:0] lowest_id;
  logic                   any_ready;

`ifdef ALARM_IRQ_EDGE_DETECT_EN
  logic [NB_CAPTURES-1:0] alarm_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) alarm_q <= '0;
    else       alarm_q <= alarm_i;
  end

  assign ev = alarm_i & ~alarm_q;
`else
  assign ev = alarm_i;
`endif

  // Descending scan so the lowest eligible index is the one left standing.
  always_comb begin
    ready     = pending_o & irq_mask_i;
    any_ready = |ready;
    lowest_id = '0;
    for (int i = NB_CAPTURES - 1; i >= 0; i--) begin
      if (ready[i]) lowest_id = ID_BITWIDTH'(i);
    end
  end

  always_comb begin
    serve_clr = '0;
    if (state == ASSERT && irq_ack_i) begin
      for (int k = 0; k < NB_CAPTURES; k++) begin
        serve_clr[k] = (irq_id_o == ID_BITWIDTH'(k));
      end
    end
  end

  // A new event on the channel being acknowledged re-arms it without counting as overrun.
  assign ovr_set = ev & pending_o & ~serve_clr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_o <= '0;
      overrun_o <= '0;
    end else begin
      pending_o <= (pending_o & ~serve_clr) | ev;
      overrun_o <= (overrun_o & ~ovr_clear_i) | ovr_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_ready) begin
            state    <= ASSERT;
            irq_o    <= 1'b1;
            irq_id_o <= lowest_id;
          end
        end
        ASSERT: begin
          if (irq_ack_i) begin
            state    <= GAP;
            irq_o    <= 1'b0;
            irq_id_o <= '0;
          end
        end
        GAP: begin
          state    <= IDLE;
          irq_o    <= 1'b0;
          irq_id_o <= '0;
        end
        default: begin
          state    <= IDLE;
          irq_o    <= 1'b0;
          irq_id_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_irq_controller.sv
// Directed bench for alarm_irq_controller; inputs change and outputs are sampled on the falling edge.
module tb_alarm_irq_controller;

  localparam int NB = 10;
  localparam int IDW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NB-1:0] alarm_i;
  logic [NB-1:0] irq_mask_i;
  logic          irq_ack_i;
  logic [NB-1:0] ovr_clear_i;
  logic          irq_o;
  logic [IDW-1:0] irq_id_o;
  logic [NB-1:0] pending_o;
  logic [NB-1:0] overrun_o;

  int total_checks = 0;
  int bad_checks   = 0;

  alarm_irq_controller #(.NB_CAPTURES(NB), .ID_BITWIDTH(IDW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .alarm_i    (alarm_i),
    .irq_mask_i (irq_mask_i),
    .irq_ack_i  (irq_ack_i),
    .ovr_clear_i(ovr_clear_i),
    .irq_o      (irq_o),
    .irq_id_o   (irq_id_o),
    .pending_o  (pending_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic checkIrq(input string tag, input logic exp_irq, input logic [IDW-1:0] exp_id);
    checkOutput({tag, ".irq"}, 32'(irq_o), 32'(exp_irq));
    checkOutput({tag, ".id"}, 32'(irq_id_o), 32'(exp_id));
  endtask

  initial begin
    rst_i       = 1'b1;
    alarm_i     = '0;
    irq_mask_i  = '1;
    irq_ack_i   = 1'b0;
    ovr_clear_i = '0;
    applyStimulus(2);
    rst_i = 1'b0;
    checkIrq("reset", 1'b0, 4'd0);
    checkOutput("reset.pending", 32'(pending_o), 32'h0);
    checkOutput("reset.overrun", 32'(overrun_o), 32'h0);

    // Basic latency: event, pending one cycle later, irq the cycle after.
    applyStimulus(1);
    alarm_i[3] = 1'b1;
    applyStimulus(1);
    alarm_i[3] = 1'b0;
    checkOutput("lat.pending", 32'(pending_o), 32'h008);
    checkIrq("lat.n1", 1'b0, 4'd0);
    applyStimulus(1);
    checkIrq("lat.n2", 1'b1, 4'd3);
    applyStimulus(1);
    checkIrq("lat.hold", 1'b1, 4'd3);
    irq_ack_i = 1'b1;
    applyStimulus(1);
    irq_ack_i = 1'b0;
    checkOutput("ack.pending", 32'(pending_o), 32'h0);
    checkIrq("ack.gap", 1'b0, 4'd0);
    applyStimulus(1);
    checkIrq("ack.idle", 1'b0, 4'd0);

    // Ack while idle is ignored.
    irq_ack_i = 1'b1;
    applyStimulus(1);
    irq_ack_i = 1'b0;
    checkIrq("idle_ack", 1'b0, 4'd0);

    // Simultaneous events on 7 and 2: service 2 first, then 7.
    alarm_i = 10'h084;
    applyStimulus(1);
    alarm_i = '0;
    checkOutput("two.pending", 32'(pending_o), 32'h084);
    applyStimulus(1);
    checkIrq("two.first", 1'b1, 4'd2);
    irq_ack_i = 1'b1;
    applyStimulus(1);
    irq_ack_i = 1'b0;
    checkIrq("two.gap", 1'b0, 4'd0);
    checkOutput("two.pending2", 32'(pending_o), 32'h080);
    applyStimulus(1);
    checkIrq("two.idle", 1'b0, 4'd0);
    applyStimulus(1);
    checkIrq("two.second", 1'b1, 4'd7);
    irq_ack_i = 1'b1;
    applyStimulus(1);
    irq_ack_i = 1'b0;
    checkOutput("two.done", 32'(pending_o), 32'h0);
    checkOutput("two.overrun", 32'(overrun_o), 32'h0);
    applyStimulus(1);

    // Overrun on channel 5 and its clear.
    alarm_i[5] = 1'b1;
    applyStimulus(1);
    alarm_i[5] = 1'b0;
    applyStimulus(1);
    checkIrq("ovr.assert", 1'b1, 4'd5);
    alarm_i[5] = 1'b1;
    applyStimulus(1);
    alarm_i[5] = 1'b0;
    checkOutput("ovr.set", 32'(overrun_o), 32'h020);
    checkOutput("ovr.pending", 32'(pending_o), 32'h020);
    irq_ack_i = 1'b1;
    applyStimulus(1);
    irq_ack_i = 1'b0;
    checkOutput("ovr.acked", 32'(pending_o), 32'h0);
    checkOutput("ovr.sticky", 32'(overrun_o), 32'h020);
    ovr_clear_i[5] = 1'b1;
    applyStimulus(1);
    ovr_clear_i[5] = 1'b0;
    checkOutput("ovr.clear", 32'(overrun_o), 32'h0);
    applyStimulus(1);

    // Event on the served channel in the ack cycle re-arms without overrun.
    alarm_i[1] = 1'b1;
    applyStimulus(1);
    alarm_i[1] = 1'b0;
    applyStimulus(1);
    checkIrq("rearm.assert", 1'b1, 4'd1);
    alarm_i[1] = 1'b1;
    irq_ack_i  = 1'b1;
    applyStimulus(1);
    alarm_i[1] = 1'b0;
    irq_ack_i  = 1'b0;
    checkOutput("rearm.pending", 32'(pending_o), 32'h002);
    checkOutput("rearm.overrun", 32'(overrun_o), 32'h0);
    checkIrq("rearm.gap", 1'b0, 4'd0);
    applyStimulus(2);
    checkIrq("rearm.again", 1'b1, 4'd1);
    irq_ack_i = 1'b1;
    applyStimulus(1);
    irq_ack_i = 1'b0;
    checkOutput("rearm.done", 32'(pending_o), 32'h0);
    applyStimulus(1);

    // Masked channel stays pending, served once unmasked.
    irq_mask_i[4] = 1'b0;
    alarm_i[4] = 1'b1;
    applyStimulus(1);
    alarm_i[4] = 1'b0;
    checkOutput("mask.pending", 32'(pending_o), 32'h010);
    applyStimulus(2);
    checkIrq("mask.blocked", 1'b0, 4'd0);
    irq_mask_i[4] = 1'b1;
    applyStimulus(2);
    checkIrq("mask.served", 1'b1, 4'd4);
    // Dropping the mask mid-service keeps the request up.
    irq_mask_i[4] = 1'b0;
    applyStimulus(1);
    checkIrq("mask.drop", 1'b1, 4'd4);
    irq_ack_i = 1'b1;
    applyStimulus(1);
    irq_ack_i = 1'b0;
    irq_mask_i = '1;
    checkOutput("mask.done", 32'(pending_o), 32'h0);
    applyStimulus(1);

    // Alarm held five cycles: one event with edge detect, repeated events otherwise.
    alarm_i[0] = 1'b1;
    applyStimulus(5);
    alarm_i[0] = 1'b0;
`ifdef ALARM_IRQ_EDGE_DETECT_EN
    checkOutput("hold.overrun", 32'(overrun_o), 32'h0);
`else
    checkOutput("hold.overrun", 32'(overrun_o), 32'h001);
`endif
    checkIrq("hold.assert", 1'b1, 4'd0);
    checkOutput("hold.pending", 32'(pending_o), 32'h001);

    // Reset during ASSERT with a concurrent ack.
    alarm_i[6] = 1'b1;
    applyStimulus(1);
    alarm_i[6] = 1'b0;
    rst_i      = 1'b1;
    irq_ack_i  = 1'b1;
    applyStimulus(1);
    rst_i     = 1'b0;
    irq_ack_i = 1'b0;
    checkIrq("rst.mid", 1'b0, 4'd0);
    checkOutput("rst.pending", 32'(pending_o), 32'h0);
    checkOutput("rst.overrun", 32'(overrun_o), 32'h0);
    applyStimulus(2);
    checkIrq("rst.after", 1'b0, 4'd0);
    checkOutput("rst.pending2", 32'(pending_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
